// File: rtl/pwm_ramp_if.sv
// Command/status bundle between a ramp master and the pwm_ramp_ctrl duty ramp engine.
// The master modport offers ramp commands and an abort, and observes the duty value and status.
interface pwm_ramp_if #(
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DUTY_W-1:0]  cfg_target;
  logic [3:0]         cfg_step;
  logic [PRESC_W-1:0] cfg_prescale;
  logic               abort;
  logic [DUTY_W-1:0]  duty_out;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_target, cfg_step, cfg_prescale, abort,
    input  cfg_ready, duty_out, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_target, cfg_step, cfg_prescale, abort,
    output cfg_ready, duty_out, busy, done
  );
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Ramps a registered PWM duty value toward a commanded target in fixed-size steps,
// one step every (prescale+1) clocks, with abort and a one-cycle completion pulse.
module pwm_ramp_ctrl #(
  parameter int DUTY_W  = 8,
  parameter int PRESC_W = 8
) (
  input  logic     clk,
  input  logic     rst,
  pwm_ramp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

  state_t             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [DUTY_W-1:0]  target_q, target_d;
  logic [3:0]         step_q, step_d;
  logic [PRESC_W-1:0] presc_q, presc_d;

  logic [DUTY_W:0]    step_w;
  logic [DUTY_W:0]    up_sum;
  logic [DUTY_W:0]    dn_diff;
  logic [DUTY_W-1:0]  next_duty;

  // Step arithmetic is one bit wider so overshoot and underflow are visible before clamping.
  always_comb begin
    step_w    = {{(DUTY_W-3){1'b0}}, step_q};
    up_sum    = {1'b0, duty_q} + step_w;
    dn_diff   = {1'b0, duty_q} - step_w;
    next_duty = target_q;
    if (step_q != 4'd0) begin
      if (target_q > duty_q) begin
        next_duty = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
      end else begin
        next_duty = (dn_diff[DUTY_W] || dn_diff <= {1'b0, target_q}) ? target_q
                                                                      : dn_diff[DUTY_W-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    step_d   = step_q;
    presc_d  = presc_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid && !bus.abort) begin
          target_d = bus.cfg_target;
          step_d   = bus.cfg_step;
          presc_d  = bus.cfg_prescale;
          cnt_d    = bus.cfg_prescale;
          state_d  = (bus.cfg_target == duty_q) ? DONE : RAMP;
        end
      end
      RAMP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          duty_d = next_duty;
          cnt_d  = presc_q;
          if (next_duty == target_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      duty_q   <= '0;
      cnt_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      presc_q  <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      step_q   <= step_d;
      presc_q  <= presc_d;
    end
  end

  // Status outputs decode directly from the state register.
  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.duty_out  = duty_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus randomized commands,
// checked every cycle against a closed-form model of the duty trajectory.
module tb_pwm_ramp_ctrl;
  localparam int DUTY_W  = 8;
  localparam int PRESC_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   errors  = 0;
  int   cur_duty = 0;

  pwm_ramp_if #(.DUTY_W(DUTY_W), .PRESC_W(PRESC_W)) bus ();

  pwm_ramp_ctrl #(.DUTY_W(DUTY_W), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Duty value n edges after accept: k = n/(p+1) steps taken, clamped at the target.
  function automatic int model_duty(int d, int t, int s, int p, int n);
    int k;
    k = n / (p + 1);
    if (t == d || k == 0) return d;
    if (s == 0) return t;
    if (t > d) return (d + k * s > t) ? t : d + k * s;
    return (d - k * s < t) ? t : d - k * s;
  endfunction

  // Edge after accept at which DONE is entered.
  function automatic int edges_to_done(int d, int t, int s, int p);
    int diff;
    if (t == d) return 0;
    if (s == 0) return p + 1;
    diff = (t > d) ? t - d : d - t;
    return ((diff + s - 1) / s) * (p + 1);
  endfunction

  task automatic test_command(input int t, input int s, input int p,
                              input int abort_at, input bit noise, input string name);
    int d, kp, exp_d;
    bit exp_busy, exp_done, exp_ready;
    d  = cur_duty;
    kp = edges_to_done(d, t, s, p);
    bus.cfg_valid    = 1'b1;
    bus.cfg_target   = DUTY_W'(t);
    bus.cfg_step     = 4'(s);
    bus.cfg_prescale = PRESC_W'(p);
    bus.abort        = 1'b0;
    @(posedge clk); #1;
    for (int n = 0; n <= kp + 1; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      if (abort_at >= 0 && n == abort_at + 1) begin
        exp_d = model_duty(d, t, s, p, abort_at);
        vectors++;
        if (bus.duty_out !== DUTY_W'(exp_d) || bus.busy !== 1'b0 ||
            bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL %s abort n=%0d: duty=%0d busy=%b done=%b ready=%b, required duty=%0d busy=0 done=0 ready=1",
                   name, n, bus.duty_out, bus.busy, bus.done, bus.cfg_ready, exp_d);
        end else begin
          $display("ok   %s abort n=%0d duty=%0d", name, n, bus.duty_out);
        end
        bus.abort = 1'b0;
        cur_duty  = exp_d;
        return;
      end
      exp_d     = model_duty(d, t, s, p, n);
      exp_busy  = (n <= kp);
      exp_done  = (n == kp);
      exp_ready = (n > kp);
      vectors++;
      if (bus.duty_out !== DUTY_W'(exp_d) || bus.busy !== exp_busy ||
          bus.done !== exp_done || bus.cfg_ready !== exp_ready) begin
        errors++;
        $display("FAIL %s n=%0d: duty=%0d busy=%b done=%b ready=%b, required duty=%0d busy=%b done=%b ready=%b",
                 name, n, bus.duty_out, bus.busy, bus.done, bus.cfg_ready,
                 exp_d, exp_busy, exp_done, exp_ready);
      end else begin
        $display("ok   %s n=%0d duty=%0d busy=%b done=%b", name, n, bus.duty_out, bus.busy, bus.done);
      end
      if (abort_at >= 0 && n == abort_at) begin
        bus.abort     = 1'b1;
        bus.cfg_valid = 1'b0;
      end else if (noise && n < kp) begin
        bus.cfg_valid    = 1'($urandom);
        bus.cfg_target   = DUTY_W'($urandom);
        bus.cfg_step     = 4'($urandom);
        bus.cfg_prescale = PRESC_W'($urandom);
      end else begin
        bus.cfg_valid = 1'b0;
      end
    end
    bus.cfg_valid = 1'b0;
    cur_duty = t;
  endtask

  task automatic test_reset();
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cur_duty = 0;
    bus.cfg_valid    = 1'b1;
    bus.cfg_target   = 8'd200;
    bus.cfg_step     = 4'd1;
    bus.cfg_prescale = 8'd1;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.abort     = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (bus.duty_out !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset cycle %0d: duty=%0d busy=%b done=%b ready=%b, required 0/0/0/1",
                 i, bus.duty_out, bus.busy, bus.done, bus.cfg_ready);
      end else begin
        $display("ok   reset cycle %0d", i);
      end
    end
    rst = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    cur_duty = 0;
  endtask

  task automatic test_abort_idle();
    bus.cfg_valid  = 1'b1;
    bus.abort      = 1'b1;
    bus.cfg_target = DUTY_W'(cur_duty ^ 8'h5A);
    bus.cfg_step   = 4'd0;
    @(posedge clk); #1;
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.duty_out !== DUTY_W'(cur_duty) || bus.busy !== 1'b0 ||
          bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: duty=%0d busy=%b done=%b ready=%b, required duty=%0d idle",
                 i, bus.duty_out, bus.busy, bus.done, bus.cfg_ready, cur_duty);
      end else begin
        $display("ok   abort_idle cycle %0d duty=%0d", i, bus.duty_out);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    int t, s, p, kp, ab;
    for (int i = 0; i < 30; i++) begin
      t  = int'($urandom_range(0, 255));
      s  = int'($urandom_range(0, 15));
      p  = int'($urandom_range(0, 3));
      kp = edges_to_done(cur_duty, t, s, p);
      ab = (kp > 1 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, kp - 1)) : -1;
      test_command(t, s, p, ab, 1'b1, "random");
    end
  endtask

  initial begin
    bus.cfg_valid    = 1'b0;
    bus.cfg_target   = '0;
    bus.cfg_step     = '0;
    bus.cfg_prescale = '0;
    bus.abort        = 1'b0;
    test_reset();
    test_command(10, 4, 1, -1, 1'b0, "up_ramp");
    test_command(3, 4, 0, -1, 1'b0, "down_clamp");
    test_command(250, 0, 0, -1, 1'b0, "jump_250");
    test_command(255, 15, 2, -1, 1'b0, "saturate");
    test_command(77, 0, 3, -1, 1'b0, "jump_77");
    test_command(42, 0, 0, -1, 1'b0, "jump_42");
    test_command(42, 5, 2, -1, 1'b0, "equal_target");
    test_command(0, 0, 0, -1, 1'b0, "jump_0");
    test_command(20, 4, 1, 4, 1'b1, "abort_ramp");
    test_abort_idle();
    test_random();
    test_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001 SHALL have parameter DUTY_W, default 8: width of the duty-cycle value driven to the PWM peripheral.
REQ-002 SHALL have parameter PRESC_W, default 8: width of the tick prescaler.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid, input, 1: new ramp command offered.
REQ-006 SHALL have port cfg_ready, output, 1: command can be accepted; high only in IDLE.
REQ-007 SHALL have port cfg_target, input, DUTY_W: final duty value.
REQ-008 SHALL have port cfg_step, input, 4: magnitude of each duty change; 0 means jump directly to target.
REQ-009 SHALL have port cfg_prescale, input, PRESC_W: value P; one step occurs every P+1 clk cycles.
REQ-010 SHALL have port abort, input, 1: stop the ramp and freeze the duty value.
REQ-011 SHALL have port duty_out, output, DUTY_W: registered duty value, connected to pwm_duty_cycle.
REQ-012 SHALL have port busy, output, 1: high in RAMP and DONE.
REQ-013 SHALL have port done, output, 1: one-cycle pulse when target is reached.

Function
REQ-014 SHALL implement states IDLE, RAMP and DONE; all outputs SHALL be registered or decoded from state only.
REQ-015 Accept SHALL occur on a clock edge where state is IDLE, cfg_valid=1 and abort=0; cfg_target, cfg_step and cfg_prescale SHALL be latched then, and later input changes SHALL be ignored.
REQ-016 On accept, if latched target equals duty_out, next state SHALL be DONE; otherwise it SHALL be RAMP, with prescale counter loaded with P.
REQ-017 In RAMP, a nonzero counter SHALL decrement; a zero counter SHALL apply one step and reload P, so the k-th step is registered k*(P+1) edges after the accept edge.
REQ-018 Up step (target > duty) SHALL be min(duty+step, target), computed at DUTY_W+1 bits with no wrap past 2^DUTY_W-1.
REQ-019 Down step (target < duty) SHALL be max(duty-step, target), computed with no underflow below 0.
REQ-020 Step 0 SHALL set duty_out to target at the first step.
REQ-021 When a step makes duty_out equal target, next state SHALL be DONE.
REQ-022 In DONE, done SHALL be 1 for exactly one cycle, then state SHALL return to IDLE; done SHALL never be 1 in any other state.
REQ-023 cfg_valid while in RAMP or DONE SHALL be ignored (cfg_ready=0); a command is not queued.
REQ-024 abort=1 in RAMP or DONE SHALL force IDLE on the next edge: duty_out held at its current value, no done pulse, any pending step discarded.
REQ-025 abort=1 in IDLE SHALL have priority over cfg_valid: no accept that cycle, no other effect.
REQ-026 duty_out SHALL change only on a step edge or on reset.

Reset
REQ-027 While rst=1 at a clock edge, state SHALL become IDLE, duty_out=0, prescale counter=0, latched config=0, done=0, busy=0, cfg_ready=1 after the edge.
REQ-028 rst SHALL override abort, cfg_valid and any ramp in progress; assertion mid-ramp SHALL give the REQ-027 values on the next edge.

Verification
REQ-029 Reset: rst=1 for 2 cycles during an active ramp -> duty_out=0, busy=0, done=0, cfg_ready=1.
REQ-030 Up ramp: duty 0, target 10, step 4, P=1 -> duty 4, 8, 10 at edges 2, 4, 6 after accept; done high for 1 cycle after edge 6; cfg_ready=1 after edge 7.
REQ-031 Down ramp with clamp: duty 10, target 3, step 4, P=0 -> duty 6 then 3 on consecutive edges, then one done pulse; duty never below 3.
REQ-032 Saturation and jump: duty 250, target 255, step 15 -> one step to 255, no wrap; step 0, target 77 -> single jump to 77 after P+1 cycles.
REQ-033 Equal target: target equals duty_out=42 -> DONE on the next edge; done pulse with duty_out unchanged at 42.
REQ-034 Abort and ignored command: abort while duty=8 on an up ramp to 20 -> IDLE, duty stays 8, no done; cfg_valid with target 0 during RAMP -> no effect on the ongoing ramp.
